mem_stage: RTL and testbench

Memory-access stage of the 5-stage CPU pipeline, directly downstream of the EX/MEM pipeline register. Consumes the registered ALU result, store data, destination register and control bits, performs load/store transactions on the data-memory req/ack port, and drives the MEM/WB boundary registers read by writeback. Stalls upstream stages while a memory transaction is outstanding and flags memory timeouts.

---
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the pipeline MEM stage and data memory.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: runs load/store transactions on the data-memory port, stalls upstream
// while one is outstanding, and drives the MEM/WB boundary registers.
//
// state  | meaning
// IDLE   | pass EX/MEM contents to WB, or launch a memory access
// ACCESS | mem_req held, waiting for mem_ack or timeout; upstream stalled
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        store_data,
  input  logic [3:0]         wr_dest,
  input  logic               wmem,
  input  logic               rmem,
  input  logic               wreg,
  input  logic               jmp,
  output logic               stall,
  mem_stage_if.master        mem,
  output logic [31:0]        wb_result,
  output logic [3:0]         wb_dest,
  output logic               wb_wreg,
  output logic               wb_jmp,
  output logic               mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] lat_alu_q, lat_alu_d;
  logic [3:0]  lat_dest_q, lat_dest_d;
  logic        lat_wreg_q, lat_wreg_d;
  logic        lat_jmp_q, lat_jmp_d;
  logic        lat_store_q, lat_store_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic        wb_jmp_q, wb_jmp_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_alu_q   <= '0;
      lat_dest_q  <= '0;
      lat_wreg_q  <= 1'b0;
      lat_jmp_q   <= 1'b0;
      lat_store_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_result_q <= '0;
      wb_dest_q   <= '0;
      wb_wreg_q   <= 1'b0;
      wb_jmp_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_alu_q   <= lat_alu_d;
      lat_dest_q  <= lat_dest_d;
      lat_wreg_q  <= lat_wreg_d;
      lat_jmp_q   <= lat_jmp_d;
      lat_store_q <= lat_store_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_result_q <= wb_result_d;
      wb_dest_q   <= wb_dest_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_jmp_q    <= wb_jmp_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_alu_d   = lat_alu_q;
    lat_dest_d  = lat_dest_q;
    lat_wreg_d  = lat_wreg_q;
    lat_jmp_d   = lat_jmp_q;
    lat_store_d = lat_store_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_result_d = wb_result_q;
    wb_dest_d   = wb_dest_q;
    wb_wreg_d   = wb_wreg_q;
    wb_jmp_d    = wb_jmp_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (wmem || rmem) begin
          // wmem wins when both are set, so the access is a store
          state_d     = ACCESS;
          cnt_d       = '0;
          lat_alu_d   = alu_result;
          lat_dest_d  = wr_dest;
          lat_wreg_d  = wreg;
          lat_jmp_d   = jmp;
          lat_store_d = wmem;
          req_d       = 1'b1;
          we_d        = wmem;
          addr_d      = alu_result;
          wdata_d     = store_data;
          wb_wreg_d   = 1'b0;
          wb_jmp_d    = 1'b0;
        end else begin
          wb_result_d = alu_result;
          wb_dest_d   = wr_dest;
          wb_wreg_d   = wreg;
          wb_jmp_d    = jmp;
        end
      end
      ACCESS: begin
        if (mem.mem_ack || (cnt_q == TO_LAST)) begin
          // timeout completes like an ack with zero read data; a real ack wins
          state_d   = IDLE;
          req_d     = 1'b0;
          wb_dest_d = lat_dest_q;
          wb_jmp_d  = lat_jmp_q;
          wb_wreg_d = lat_wreg_q && !lat_store_q;
          if (lat_store_q)
            wb_result_d = lat_alu_q;
          else if (mem.mem_ack)
            wb_result_d = mem.mem_rdata;
          else
            wb_result_d = '0;
          if (!mem.mem_ack)
            err_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          wb_wreg_d = 1'b0;
          wb_jmp_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall         = (state_q == ACCESS);
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign wb_result     = wb_result_q;
  assign wb_dest       = wb_dest_q;
  assign wb_wreg       = wb_wreg_q;
  assign wb_jmp        = wb_jmp_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a driver issues instructions and pushes hand-computed
// WB results; a monitor pops and compares whenever a WB result appears.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [3:0]  dest;
    logic        wmem;
    logic        rmem;
    logic        wreg;
    logic        jmp;
  } instr_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  dest;
    logic        wreg;
    logic        jmp;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_result = '0, store_data = '0;
  logic [3:0]  wr_dest = '0;
  logic        wmem = 1'b0, rmem = 1'b0, wreg = 1'b0, jmp = 1'b0;
  logic        stall;
  logic [31:0] wb_result;
  logic [3:0]  wb_dest;
  logic        wb_wreg, wb_jmp, mem_err;

  mem_stage_if mbus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .store_data (store_data),
    .wr_dest    (wr_dest),
    .wmem       (wmem),
    .rmem       (rmem),
    .wreg       (wreg),
    .jmp        (jmp),
    .stall      (stall),
    .mem        (mbus),
    .wb_result  (wb_result),
    .wb_dest    (wb_dest),
    .wb_wreg    (wb_wreg),
    .wb_jmp     (wb_jmp),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  exp_t exp_q[$];
  logic stall_prev = 1'b0;

  localparam instr_t BUBBLE = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] s, input logic [3:0] d,
                                input logic w, input logic r, input logic wr, input logic j);
    instr_t i;
    i.alu = a; i.sd = s; i.dest = d; i.wmem = w; i.rmem = r; i.wreg = wr; i.jmp = j;
    return i;
  endfunction

  function automatic exp_t mke(input logic [31:0] r, input logic [3:0] d, input logic wr,
                               input logic j, input logic e);
    exp_t x;
    x.result = r; x.dest = d; x.wreg = wr; x.jmp = j; x.err = e;
    return x;
  endfunction

  task automatic drive(input instr_t i);
    alu_result = i.alu; store_data = i.sd; wr_dest = i.dest;
    wmem = i.wmem; rmem = i.rmem; wreg = i.wreg; jmp = i.jmp;
  endtask

  // Called at a negedge; the instruction is captured on the following posedge.
  task automatic pass(input instr_t i, input exp_t e);
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic mem_op(input string tag, input instr_t i, input exp_t e, input int delay,
                        input logic [31:0] rdata, input instr_t nxt, input exp_t en,
                        input int exp_stall);
    int n;
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
    drive(nxt);
    if (nxt.wreg || nxt.jmp) exp_q.push_back(en);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!stall) break;
      n++;
      chk({tag, "_req"},   32'(mbus.mem_req), 32'd1);
      chk({tag, "_addr"},  mbus.mem_addr, i.alu);
      chk({tag, "_we"},    32'(mbus.mem_we), 32'(i.wmem));
      chk({tag, "_wdata"}, mbus.mem_wdata, i.sd);
      if (k == delay) begin
        mbus.mem_ack = 1'b1;
        mbus.mem_rdata = rdata;
      end
      @(negedge clk);
      mbus.mem_ack = 1'b0;
      mbus.mem_rdata = '0;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_req_drop"}, 32'(mbus.mem_req), 32'd0);
    if (nxt.wreg || nxt.jmp) begin
      @(negedge clk);
      drive(BUBBLE);
    end
  endtask

  // Monitor: a WB result is presented when a stall ends, or when an unstalled
  // cycle shows a register write or jump.
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if ((stall_prev && !stall) || (!stall_prev && !stall && (wb_wreg || wb_jmp))) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_wb: got result %h dest %0d with no expected entry", wb_result, wb_dest);
        end else begin
          x = exp_q.pop_front();
          chk("wb_result", wb_result, x.result);
          chk("wb_dest",   32'(wb_dest), 32'(x.dest));
          chk("wb_wreg",   32'(wb_wreg), 32'(x.wreg));
          chk("wb_jmp",    32'(wb_jmp), 32'(x.jmp));
          chk("mem_err",   32'(mem_err), 32'(x.err));
        end
      end
      stall_prev = stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mbus.mem_ack = 1'b0;
    mbus.mem_rdata = '0;
    #12;
    chk("rst_stall",     32'(stall), 32'd0);
    chk("rst_req",       32'(mbus.mem_req), 32'd0);
    chk("rst_we",        32'(mbus.mem_we), 32'd0);
    chk("rst_addr",      mbus.mem_addr, 32'd0);
    chk("rst_wdata",     mbus.mem_wdata, 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_wb_flags",  {26'd0, wb_dest, wb_wreg, wb_jmp}, 32'd0);
    chk("rst_err",       32'(mem_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // pass-through
    pass(mk(32'h1234, 32'h0, 4'd5, 0, 0, 1, 0), mke(32'h1234, 4'd5, 1, 0, 0));
    chk("pass_stall", 32'(stall), 32'd0);

    // load, ack in first ACCESS cycle
    mem_op("ld0", mk(32'h100, 32'h0, 4'd3, 0, 1, 1, 0), mke(32'hDEADBEEF, 4'd3, 1, 0, 0),
           0, 32'hDEADBEEF, BUBBLE, '0, 1);

    // store, ack on the fourth ACCESS cycle (also the timeout cycle: ack wins);
    // next instruction is held at the inputs during the stall
    mem_op("st3", mk(32'h200, 32'hA5A5A5A5, 4'd7, 1, 0, 1, 0), mke(32'h200, 4'd7, 0, 0, 0),
           3, 32'h0, mk(32'h55, 32'h0, 4'd9, 0, 0, 1, 0), mke(32'h55, 4'd9, 1, 0, 0), 4);

    // load timeout: zero data, mem_err set
    mem_op("tmo", mk(32'h300, 32'h0, 4'd2, 0, 1, 1, 0), mke(32'h0, 4'd2, 1, 0, 1),
           -1, 32'h0, BUBBLE, '0, 4);
    pass(mk(32'h77, 32'h0, 4'd4, 0, 0, 1, 0), mke(32'h77, 4'd4, 1, 0, 1));

    // wmem and rmem both set: store behaviour
    mem_op("both", mk(32'h400, 32'h11, 4'd6, 1, 1, 1, 0), mke(32'h400, 4'd6, 0, 0, 1),
           1, 32'hFFFF0000, BUBBLE, '0, 2);

    // reset two cycles into a load
    drive(mk(32'h500, 32'h0, 4'd1, 0, 1, 1, 0));
    @(negedge clk);
    drive(BUBBLE);
    chk("rsta_stall_pre", 32'(stall), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rsta_req",       32'(mbus.mem_req), 32'd0);
    chk("rsta_stall",     32'(stall), 32'd0);
    chk("rsta_wb_result", wb_result, 32'd0);
    chk("rsta_wb_flags",  {26'd0, wb_dest, wb_wreg, wb_jmp}, 32'd0);
    chk("rsta_err",       32'(mem_err), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    mbus.mem_ack = 1'b1;
    mbus.mem_rdata = 32'h99;
    @(negedge clk);
    mbus.mem_ack = 1'b0;
    mbus.mem_rdata = '0;
    chk("late_ack_result", wb_result, 32'd0);
    chk("late_ack_wreg",   32'(wb_wreg), 32'd0);
    chk("late_ack_stall",  32'(stall), 32'd0);
    chk("late_ack_req",    32'(mbus.mem_req), 32'd0);

    // back-to-back loads, jmp only on the second
    mem_op("bb1", mk(32'h600, 32'h0, 4'd1, 0, 1, 1, 0), mke(32'h11110000, 4'd1, 1, 0, 0),
           1, 32'h11110000, BUBBLE, '0, 2);
    mem_op("bb2", mk(32'h604, 32'h0, 4'd8, 0, 1, 1, 1), mke(32'h22220000, 4'd8, 1, 1, 0),
           0, 32'h22220000, BUBBLE, '0, 1);

    // stray ack while idle
    drive(BUBBLE);
    mbus.mem_ack = 1'b1;
    mbus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mbus.mem_ack = 1'b0;
    mbus.mem_rdata = '0;
    chk("stray_result", wb_result, 32'd0);
    chk("stray_flags",  {30'd0, wb_wreg, wb_jmp}, 32'd0);
    chk("stray_stall",  32'(stall), 32'd0);
    chk("stray_req",    32'(mbus.mem_req), 32'd0);
    chk("stray_err",    32'(mem_err), 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
